// File: rtl/fb_cpu_pkg.sv
// Shared types for the FB accumulator CPU: opcode and FSM state encodings, default widths.
// The optional multiplier is enabled with the FBCPU_MUL_EN macro (see fb_cpu_alu / fb_cpu).
package fb_cpu_pkg;

  localparam int FB_ADDRESS_WIDTH = 6;
  localparam int FB_OPCODE_WIDTH  = 4;
  localparam int FB_DATA_WIDTH    = FB_ADDRESS_WIDTH + FB_OPCODE_WIDTH;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_SHL = 4'd3,
    OP_SHR = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_NOT = 4'd7,
    OP_LDA = 4'd8,
    OP_STA = 4'd9,
    OP_BRA = 4'd10,
    OP_BZ  = 4'd11,
    OP_BNZ = 4'd12,
    OP_LDI = 4'd13,
    OP_NOP = 4'd14,
    OP_HLT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_FETCH_W = 3'd1,
    ST_DECODE  = 3'd2,
    ST_MEM_W   = 3'd3,
    ST_EXEC    = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  // An instruction word is {opcode, operand}, so the data word must hold both exactly.
  function automatic bit widths_ok(int aw, int dw);
    return dw == aw + FB_OPCODE_WIDTH;
  endfunction

endpackage

// File: rtl/fb_cpu_alu.sv
// Combinational ALU of the FB CPU: (opcode, ACC, operand value) -> new ACC value.
// Multiplication is only built when FBCPU_MUL_EN is defined; otherwise opcode 2 returns ACC.
module fb_cpu_alu
  import fb_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  opcode_e               op,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] m,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = acc;
    case (op)
      OP_ADD: result = acc + m;
      OP_SUB: result = acc - m;
`ifdef FBCPU_MUL_EN
      OP_MUL: result = acc * m;
`endif
      OP_AND: result = acc & m;
      OP_OR:  result = acc | m;
      OP_LDA: result = m;
      OP_SHL: result = acc << 1;
      OP_SHR: result = acc >> 1;
      OP_NOT: result = ~acc;
      OP_LDI: result = m;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/fb_cpu.sv
// FB accumulator CPU core: multi-cycle FSM fetching 10-bit instructions from an external
// synchronous RAM. Define FBCPU_MUL_EN to make opcode 2 a multiply (otherwise a NOP).
module fb_cpu
  import fb_cpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = FB_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [DATA_WIDTH-1:0]    MDRIn,
  output logic                     RAMWr,
  output logic [ADDRESS_WIDTH-1:0] MAR,
  input  logic [DATA_WIDTH-1:0]    MDROut,
  output logic [ADDRESS_WIDTH-1:0] PC
);

  if (!widths_ok(ADDRESS_WIDTH, DATA_WIDTH)) begin : g_width_check
    $error("fb_cpu: DATA_WIDTH must equal ADDRESS_WIDTH + 4");
  end

  state_e                   state_q, state_d;
  opcode_e                  ir_q, ir_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0]    mdr_in_q, mdr_in_d;
  logic                     ram_wr_q, ram_wr_d;
  logic [DATA_WIDTH-1:0]    acc_q, acc_d;

  opcode_e                  dec_op;
  logic [ADDRESS_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0]    operand_ext;
  logic                     acc_zero;
  opcode_e                  alu_op;
  logic [DATA_WIDTH-1:0]    alu_m;
  logic [DATA_WIDTH-1:0]    alu_res;

  assign dec_op      = opcode_e'(MDROut[DATA_WIDTH-1 -: FB_OPCODE_WIDTH]);
  assign operand     = MDROut[ADDRESS_WIDTH-1:0];
  assign operand_ext = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, operand};
  assign acc_zero    = (acc_q == '0);

  fb_cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op    (alu_op),
    .acc   (acc_q),
    .m     (alu_m),
    .result(alu_res)
  );

  // Only the opcode of IR is kept: the operand is consumed in DECODE, EXEC needs the opcode.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    mar_d    = mar_q;
    mdr_in_d = mdr_in_q;
    ram_wr_d = ram_wr_q;
    acc_d    = acc_q;
    alu_op   = ir_q;
    alu_m    = MDROut;

    case (state_q)
      ST_FETCH: begin
        mar_d    = pc_q;
        ram_wr_d = 1'b0;
        state_d  = ST_FETCH_W;
      end

      ST_FETCH_W: state_d = ST_DECODE;

      ST_DECODE: begin
        ir_d    = dec_op;
        pc_d    = pc_q + ADDRESS_WIDTH'(1);
        state_d = ST_FETCH;
        case (dec_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDA: begin
            mar_d   = operand;
            state_d = ST_MEM_W;
          end
`ifdef FBCPU_MUL_EN
          OP_MUL: begin
            mar_d   = operand;
            state_d = ST_MEM_W;
          end
`endif
          // The write itself lands on the following FETCH edge.
          OP_STA: begin
            mar_d    = operand;
            mdr_in_d = acc_q;
            ram_wr_d = 1'b1;
          end
          OP_SHL, OP_SHR, OP_NOT, OP_LDI: begin
            alu_op = dec_op;
            alu_m  = operand_ext;
            acc_d  = alu_res;
          end
          OP_BRA: pc_d = operand;
          OP_BZ:  if (acc_zero) pc_d = operand;
          OP_BNZ: if (!acc_zero) pc_d = operand;
          OP_HLT: state_d = ST_HALT;
          default: ;
        endcase
      end

      ST_MEM_W: state_d = ST_EXEC;

      ST_EXEC: begin
        acc_d   = alu_res;
        state_d = ST_FETCH;
      end

      ST_HALT: ram_wr_d = 1'b0;

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= OP_ADD;
      pc_q     <= '0;
      mar_q    <= '0;
      mdr_in_q <= '0;
      ram_wr_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      mdr_in_q <= mdr_in_d;
      ram_wr_q <= ram_wr_d;
      acc_q    <= acc_d;
    end
  end

  assign MDRIn = mdr_in_q;
  assign RAMWr = ram_wr_q;
  assign MAR   = mar_q;
  assign PC    = pc_q;

endmodule

// File: tb/tb_fb_cpu.sv
// Testbench for fb_cpu: RAM model, instruction-level reference interpreter,
// directed programs plus random forward-branching programs.
module tb_fb_cpu;

  localparam int opAdd = 0, opSub = 1, opMul = 2, opShl = 3, opShr = 4, opAnd = 5;
  localparam int opOr = 6, opNot = 7, opLda = 8, opSta = 9, opBra = 10, opBz = 11;
  localparam int opBnz = 12, opLdi = 13, opNop = 14, opHlt = 15;

`ifdef FBCPU_MUL_EN
  localparam bit mulOn = 1'b1;
`else
  localparam bit mulOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] mdrIn;
  logic       ramWr;
  logic [5:0] mar;
  logic [9:0] mdrOut = '0;
  logic [5:0] pc;
  logic       loadReq = 1'b0;

  logic [9:0] ram[64];
  logic [9:0] img[64];
  int         refMem[64];
  int         checkCount = 0;
  int         errorCount = 0;

  always #5 clk = ~clk;

  fb_cpu #(
    .ADDRESS_WIDTH(6),
    .DATA_WIDTH(10)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .MDRIn (mdrIn),
    .RAMWr (ramWr),
    .MAR   (mar),
    .MDROut(mdrOut),
    .PC    (pc)
  );

  // Synchronous single-port RAM with one-cycle read latency; loadReq copies the image in.
  always @(posedge clk) begin
    if (loadReq) begin
      for (int i = 0; i < 64; i++) ram[i] <= img[i];
    end else if (ramWr) begin
      ram[mar] <= mdrIn;
    end
    mdrOut <= ram[mar];
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [9:0] makeInstr(input int op, input int a);
    logic [9:0] w;
    w = {op[3:0], a[5:0]};
    return w;
  endfunction

  task automatic clearImg();
    for (int i = 0; i < 64; i++) img[i] = makeInstr(opHlt, 0);
  endtask

  // Instruction-level interpreter: returns total cycles to HALT, address of the HLT and final PC.
  task automatic runModel(output int cyc, output int hltPc, output int endPc);
    int acc, p, np, op, a, m, lat, steps;
    bit done;
    acc = 0; p = 0; steps = 0; done = 0; cyc = 0; hltPc = -1;
    while (!done && steps < 5000) begin
      op = refMem[p] / 64;
      a = refMem[p] % 64;
      m = refMem[a];
      np = (p + 1) % 64;
      lat = 3;
      steps++;
      case (op)
        opAdd: begin acc = (acc + m) % 1024; lat = 5; end
        opSub: begin acc = (acc + 1024 - m) % 1024; lat = 5; end
        opMul: if (mulOn) begin acc = (acc * m) % 1024; lat = 5; end
        opAnd: begin acc = acc & m; lat = 5; end
        opOr:  begin acc = acc | m; lat = 5; end
        opLda: begin acc = m; lat = 5; end
        opSta: refMem[a] = acc;
        opShl: acc = (acc * 2) % 1024;
        opShr: acc = acc / 2;
        opNot: acc = 1023 - acc;
        opLdi: acc = a;
        opBra: np = a;
        opBz:  if (acc == 0) np = a;
        opBnz: if (acc != 0) np = a;
        opHlt: begin done = 1; hltPc = p; end
        default: ;
      endcase
      cyc += lat;
      p = np;
    end
    endPc = p;
    if (!done) cyc = 200;
  endtask

  task automatic resetAndLoad(input string name);
    @(negedge clk);
    rst = 1'b0;
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput({name, ":rst_pc"}, pc, 0);
    checkOutput({name, ":rst_mar"}, mar, 0);
    checkOutput({name, ":rst_mdrin"}, mdrIn, 0);
    checkOutput({name, ":rst_ramwr"}, ramWr, 0);
  endtask

  // Runs the program in img and compares timing, final PC and the whole memory with the model.
  task automatic applyStimulus(input string name);
    int cyc, hltPc, endPc;
    for (int i = 0; i < 64; i++) refMem[i] = int'(img[i]);
    runModel(cyc, hltPc, endPc);
    resetAndLoad(name);
    rst = 1'b1;
    repeat (cyc - 1) @(posedge clk);
    #1;
    checkOutput({name, ":pc_at_hlt"}, pc, hltPc);
    @(posedge clk);
    #1;
    checkOutput({name, ":pc_halted"}, pc, endPc);
    repeat (4) @(posedge clk);
    #1;
    checkOutput({name, ":pc_hold"}, pc, endPc);
    checkOutput({name, ":ramwr_halt"}, ramWr, 0);
    for (int i = 0; i < 64; i++)
      checkOutput($sformatf("%s:mem%0d", name, i), ram[i], refMem[i]);
  endtask

  initial begin
    int op, a;

    $display("[TB] directed program 1: add and store");
    clearImg();
    img[0] = makeInstr(opLda, 50); img[1] = makeInstr(opAdd, 51);
    img[2] = makeInstr(opSta, 52); img[3] = makeInstr(opHlt, 0);
    img[50] = 10'd7; img[51] = 10'd8; img[52] = 10'd0;
    applyStimulus("t1");
    checkOutput("t1:sum", ram[52], 15);
    checkOutput("t1:pc", pc, 4);

    $display("[TB] directed program 2: counted loop");
    clearImg();
    img[0] = makeInstr(opLda, 52); img[1] = makeInstr(opAdd, 51);
    img[2] = makeInstr(opSta, 52); img[3] = makeInstr(opLda, 53);
    img[4] = makeInstr(opSub, 54); img[5] = makeInstr(opSta, 53);
    img[6] = makeInstr(opBnz, 0);  img[7] = makeInstr(opHlt, 0);
    img[51] = 10'd5; img[52] = 10'd0; img[53] = 10'd10; img[54] = 10'd1;
    applyStimulus("t2");
    checkOutput("t2:sum", ram[52], 50);
    checkOutput("t2:count", ram[53], 0);

    $display("[TB] directed program 3: wrap, shift, invert");
    clearImg();
    img[0] = makeInstr(opLdi, 3);  img[1] = makeInstr(opSub, 51);
    img[2] = makeInstr(opSta, 55); img[3] = makeInstr(opLda, 56);
    img[4] = makeInstr(opShl, 0);  img[5] = makeInstr(opSta, 57);
    img[6] = makeInstr(opLdi, 0);  img[7] = makeInstr(opNot, 0);
    img[8] = makeInstr(opSta, 58); img[9] = makeInstr(opLdi, 7);
    img[10] = makeInstr(opShr, 0); img[11] = makeInstr(opSta, 59);
    img[12] = makeInstr(opHlt, 0);
    img[51] = 10'd5; img[56] = 10'h200; img[57] = 10'd99;
    applyStimulus("t3");
    checkOutput("t3:sub_wrap", ram[55], 1022);
    checkOutput("t3:shl_out", ram[57], 0);
    checkOutput("t3:not_zero", ram[58], 1023);
    checkOutput("t3:shr", ram[59], 3);

    $display("[TB] directed program 4: conditional branches");
    clearImg();
    img[0] = makeInstr(opLdi, 0); img[1] = makeInstr(opBz, 5);
    img[2] = makeInstr(opLdi, 9); img[3] = makeInstr(opSta, 60);
    img[5] = makeInstr(opBnz, 9); img[6] = makeInstr(opHlt, 0);
    img[9] = makeInstr(opSta, 61); img[60] = 10'd1; img[61] = 10'd1;
    applyStimulus("t4");
    checkOutput("t4:pc", pc, 7);
    checkOutput("t4:bz_skipped_sta", ram[60], 1);
    checkOutput("t4:bnz_skipped_sta", ram[61], 1);

    $display("[TB] directed program 7: PC wraps past 63");
    clearImg();
    img[0] = makeInstr(opBz, 3);  img[1] = makeInstr(opHlt, 0);
    img[3] = makeInstr(opLdi, 1); img[4] = makeInstr(opBra, 63);
    img[63] = makeInstr(opNop, 0);
    applyStimulus("t7");
    checkOutput("t7:pc", pc, 2);

    $display("[TB] directed program 6: opcode 2");
    clearImg();
    img[0] = makeInstr(opLdi, 6); img[1] = makeInstr(opMul, 51);
    img[2] = makeInstr(opSta, 52); img[3] = makeInstr(opHlt, 0);
    img[51] = 10'd9; img[52] = 10'd0;
    applyStimulus("t6");
    checkOutput("t6:mul", ram[52], mulOn ? 54 : 6);

    $display("[TB] directed test 5: reset during store");
    clearImg();
    img[0] = makeInstr(opLdi, 5); img[1] = makeInstr(opSta, 52);
    img[2] = makeInstr(opHlt, 0); img[52] = 10'd99;
    resetAndLoad("t5");
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t5:wr_pending", ramWr, 1);
    checkOutput("t5:mar_pending", mar, 52);
    checkOutput("t5:mdrin_pending", mdrIn, 5);
    rst = 1'b0;
    #1;
    checkOutput("t5:ramwr_cleared", ramWr, 0);
    checkOutput("t5:mar_cleared", mar, 0);
    checkOutput("t5:mdrin_cleared", mdrIn, 0);
    checkOutput("t5:pc_cleared", pc, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5:mem_unchanged", ram[52], 99);

    $display("[TB] random programs");
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 30; i++) begin
        op = $urandom_range(0, 14);
        a = $urandom_range(0, 63);
        if (op == opSta) a = $urandom_range(40, 63);
        if (op == opBra || op == opBz || op == opBnz) a = $urandom_range(i + 1, 30);
        img[i] = makeInstr(op, a);
      end
      img[30] = makeInstr(opHlt, 0);
      for (int i = 31; i < 64; i++) img[i] = 10'($urandom_range(0, 1023));
      applyStimulus($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
